// File: rtl/mmc3_scanline_irq.sv
// MMC3-compatible scanline IRQ: register decode, A12 edge filter,
// reload/decrement counter and active-low irq output.
module mmc3_scanline_irq #(
  parameter int A12_FILTER = 2
) (
  input  logic        m2,
  input  logic        reset,
  input  logic        enable,
  input  logic        romsel,
  input  logic        cpu_rw_in,
  input  logic [14:0] cpu_addr_in,
  input  logic [7:0]  cpu_data_in,
  input  logic        ppu_a12,
  output logic        irq,
  output logic [7:0]  irq_counter
);

  localparam logic [1:0] FILT = 2'(A12_FILTER);

  logic       sync1_q, sync1_d;
  logic       a12_s_q, a12_s_d;
  logic [1:0] low_cnt_q, low_cnt_d;
  logic [7:0] latch_q, latch_d;
  logic [7:0] counter_q, counter_d;
  logic       reload_q, reload_d;
  logic       irq_en_q, irq_en_d;
  logic       pending_q, pending_d;

  logic       wr;
  logic       wr_c000, wr_c001, wr_e000, wr_e001;
  logic       clk_ev;
  logic [1:0] sel;
  logic       unused_addr;

  assign unused_addr = ^cpu_addr_in[12:1];

  assign wr  = enable & ~romsel & ~cpu_rw_in & cpu_addr_in[14];
  assign sel = {cpu_addr_in[13], cpu_addr_in[0]};

  assign wr_c000 = wr & (sel == 2'b00);
  assign wr_c001 = wr & (sel == 2'b01);
  assign wr_e000 = wr & (sel == 2'b10);
  assign wr_e001 = wr & (sel == 2'b11);

  // A nonzero low count already implies the previous a12_s was low.
  assign clk_ev = a12_s_q & (low_cnt_q >= FILT);

  always_comb begin
    sync1_d   = ppu_a12;
    a12_s_d   = sync1_q;
    low_cnt_d = low_cnt_q;
    latch_d   = latch_q;
    counter_d = counter_q;
    reload_d  = reload_q;
    irq_en_d  = irq_en_q;
    pending_d = pending_q;

    if (a12_s_q)
      low_cnt_d = 2'd0;
    else if (low_cnt_q != 2'd3)
      low_cnt_d = low_cnt_q + 2'd1;

    if (wr_c000)
      latch_d = cpu_data_in;

    if (wr_c001) begin
      reload_d  = 1'b1;
      counter_d = 8'd0;
    end

    // Same-edge $C001 counts as reload; event always uses the old latch.
    if (clk_ev) begin
      if (counter_q == 8'd0 || reload_q || wr_c001) begin
        counter_d = latch_q;
        reload_d  = 1'b0;
      end else begin
        counter_d = counter_q - 8'd1;
      end
      if (counter_d == 8'd0 && irq_en_q)
        pending_d = 1'b1;
    end

    if (wr_e000) begin
      irq_en_d  = 1'b0;
      pending_d = 1'b0;
    end

    if (wr_e001)
      irq_en_d = 1'b1;

    if (!enable) begin
      sync1_d   = 1'b0;
      a12_s_d   = 1'b0;
      low_cnt_d = 2'd0;
      latch_d   = 8'd0;
      counter_d = 8'd0;
      reload_d  = 1'b0;
      irq_en_d  = 1'b0;
      pending_d = 1'b0;
    end
  end

  always_ff @(posedge m2) begin
    if (reset) begin
      sync1_q   <= 1'b0;
      a12_s_q   <= 1'b0;
      low_cnt_q <= 2'd0;
      latch_q   <= 8'd0;
      counter_q <= 8'd0;
      reload_q  <= 1'b0;
      irq_en_q  <= 1'b0;
      pending_q <= 1'b0;
    end else begin
      sync1_q   <= sync1_d;
      a12_s_q   <= a12_s_d;
      low_cnt_q <= low_cnt_d;
      latch_q   <= latch_d;
      counter_q <= counter_d;
      reload_q  <= reload_d;
      irq_en_q  <= irq_en_d;
      pending_q <= pending_d;
    end
  end

  assign irq         = ~pending_q;
  assign irq_counter = counter_q;

endmodule

// File: tb/tb_mmc3_scanline_irq.sv
// Directed bench for mmc3_scanline_irq with an expected-value queue
// popped after each stimulus step.
module tb_mmc3_scanline_irq;

  logic        m2 = 1'b0;
  logic        reset;
  logic        enable;
  logic        romsel;
  logic        cpu_rw_in;
  logic [14:0] cpu_addr_in;
  logic [7:0]  cpu_data_in;
  logic        ppu_a12;
  logic        irq;
  logic [7:0]  irq_counter;

  int tests = 0;
  int fails = 0;

  string      tag_q[$];
  logic       irq_q[$];
  logic [7:0] cnt_q[$];

  localparam logic [14:0] A_C000 = 15'h4000;
  localparam logic [14:0] A_C001 = 15'h4001;
  localparam logic [14:0] A_E000 = 15'h6000;
  localparam logic [14:0] A_E001 = 15'h6001;

  mmc3_scanline_irq #(.A12_FILTER(2)) dut (
    .m2          (m2),
    .reset       (reset),
    .enable      (enable),
    .romsel      (romsel),
    .cpu_rw_in   (cpu_rw_in),
    .cpu_addr_in (cpu_addr_in),
    .cpu_data_in (cpu_data_in),
    .ppu_a12     (ppu_a12),
    .irq         (irq),
    .irq_counter (irq_counter)
  );

  always #5 m2 = ~m2;

  task automatic expect_out(input string tag, input logic e_irq,
                            input logic [7:0] e_cnt);
    tag_q.push_back(tag);
    irq_q.push_back(e_irq);
    cnt_q.push_back(e_cnt);
  endtask

  task automatic check();
    string      t;
    logic       ei;
    logic [7:0] ec;
    t  = tag_q.pop_front();
    ei = irq_q.pop_front();
    ec = cnt_q.pop_front();
    tests++;
    assert (irq === ei && irq_counter === ec) else begin
      fails++;
      $error("FAIL %s: irq=%b cnt=%0d, expected irq=%b cnt=%0d",
             t, irq, irq_counter, ei, ec);
    end
  endtask

  task automatic cpu_write(input logic [14:0] a, input logic [7:0] d);
    romsel      = 1'b0;
    cpu_rw_in   = 1'b0;
    cpu_addr_in = a;
    cpu_data_in = d;
    @(negedge m2);
    romsel    = 1'b1;
    cpu_rw_in = 1'b1;
  endtask

  task automatic step_write(input string tag, input logic [14:0] a,
                            input logic [7:0] d, input logic e_irq,
                            input logic [7:0] e_cnt);
    expect_out(tag, e_irq, e_cnt);
    cpu_write(a, d);
    check();
  endtask

  // Low for 4 cycles then high; the event lands on the third edge after the rise.
  task automatic pulse(input string tag, input logic e_irq,
                       input logic [7:0] e_cnt);
    expect_out(tag, e_irq, e_cnt);
    ppu_a12 = 1'b0;
    repeat (4) @(negedge m2);
    ppu_a12 = 1'b1;
    repeat (4) @(negedge m2);
    check();
  endtask

  task automatic pulse_with_write(input string tag, input logic [14:0] a,
                                  input logic [7:0] d, input logic e_irq,
                                  input logic [7:0] e_cnt);
    expect_out(tag, e_irq, e_cnt);
    ppu_a12 = 1'b0;
    repeat (4) @(negedge m2);
    ppu_a12 = 1'b1;
    repeat (2) @(negedge m2);
    cpu_write(a, d);
    @(negedge m2);
    check();
  endtask

  initial begin
    reset       = 1'b1;
    enable      = 1'b1;
    romsel      = 1'b1;
    cpu_rw_in   = 1'b1;
    cpu_addr_in = '0;
    cpu_data_in = '0;
    ppu_a12     = 1'b0;
    repeat (3) @(negedge m2);
    reset = 1'b0;
    expect_out("reset", 1'b1, 8'd0);
    @(negedge m2);
    check();

    step_write("wr_c000", A_C000, 8'd3, 1'b1, 8'd0);
    step_write("wr_c001", A_C001, 8'd0, 1'b1, 8'd0);
    step_write("wr_e001", A_E001, 8'd0, 1'b1, 8'd0);
    pulse("p1_reload", 1'b1, 8'd3);
    pulse("p2", 1'b1, 8'd2);
    pulse("p3", 1'b1, 8'd1);
    pulse("p4_zero", 1'b0, 8'd0);

    step_write("e000_ack", A_E000, 8'd0, 1'b1, 8'd0);
    step_write("e001_noirq", A_E001, 8'd0, 1'b1, 8'd0);
    pulse("re_p1", 1'b1, 8'd3);
    pulse("re_p2", 1'b1, 8'd2);
    pulse("re_p3", 1'b1, 8'd1);
    pulse("re_p4", 1'b0, 8'd0);

    step_write("e000_clr", A_E000, 8'd0, 1'b1, 8'd0);
    expect_out("glitch", 1'b1, 8'd0);
    for (int i = 0; i < 10; i++) begin
      ppu_a12 = 1'b0;
      @(negedge m2);
      ppu_a12 = 1'b1;
      @(negedge m2);
    end
    repeat (3) @(negedge m2);
    check();

    step_write("e001_b", A_E001, 8'd0, 1'b1, 8'd0);
    step_write("c000_5", A_C000, 8'd5, 1'b1, 8'd0);
    pulse("l5_p1", 1'b1, 8'd5);
    pulse("l5_p2", 1'b1, 8'd4);
    pulse_with_write("c001_same_edge", A_C001, 8'd0, 1'b1, 8'd5);
    pulse("reload_cleared", 1'b1, 8'd4);
    pulse("l5_p3", 1'b1, 8'd3);
    pulse("l5_p4", 1'b1, 8'd2);
    pulse("l5_p5", 1'b1, 8'd1);
    pulse_with_write("e000_same_edge", A_E000, 8'd0, 1'b1, 8'd0);
    pulse("disabled_reload", 1'b1, 8'd5);

    step_write("e001_c", A_E001, 8'd0, 1'b1, 8'd5);
    pulse("d4", 1'b1, 8'd4);
    pulse("d3", 1'b1, 8'd3);
    pulse("d2", 1'b1, 8'd2);
    pulse("d1", 1'b1, 8'd1);
    pulse("d0", 1'b0, 8'd0);

    expect_out("enable_low", 1'b1, 8'd0);
    enable = 1'b0;
    @(negedge m2);
    check();
    cpu_write(A_C000, 8'd9);
    pulse("disabled_pulse", 1'b1, 8'd0);
    enable = 1'b1;
    expect_out("reenable", 1'b1, 8'd0);
    @(negedge m2);
    check();
    pulse("latch0_noen", 1'b1, 8'd0);
    step_write("e001_d", A_E001, 8'd0, 1'b1, 8'd0);
    pulse("latch0_ev1", 1'b0, 8'd0);
    step_write("e000_d", A_E000, 8'd0, 1'b1, 8'd0);
    step_write("e001_e", A_E001, 8'd0, 1'b1, 8'd0);
    pulse("latch0_ev2", 1'b0, 8'd0);

    step_write("c000_7", A_C000, 8'd7, 1'b0, 8'd0);
    pulse("pre_reset", 1'b0, 8'd7);
    expect_out("mid_reset", 1'b1, 8'd0);
    reset = 1'b1;
    @(negedge m2);
    reset = 1'b0;
    check();
    pulse("post_reset_latch0", 1'b1, 8'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
